// File: rtl/unroller.sv
// unroller: collects K = NUM/ROLL_NUM narrow input beats of ROLL_NUM lanes
// each into one wide output beat of NUM lanes. It uses valid/ready handshakes
// on both sides and can stream back-to-back without a bubble.
// Optional feature: define UNROLLER_FLUSH_EN to add a 'flush' input. A flush
// emits a partially filled set, with the lanes that were not written zeroed.
module unroller #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM        = 4,
  parameter int ROLL_NUM   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
`ifdef UNROLLER_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int K     = NUM / ROLL_NUM;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  // Reject configurations where the input lanes do not tile the output evenly.
  generate
    if ((NUM % ROLL_NUM) != 0 || ROLL_NUM > NUM) begin : g_bad_cfg
      $error("unroller: NUM must be a multiple of ROLL_NUM and ROLL_NUM <= NUM");
    end
  endgenerate

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_data     [NUM-1:0];
  logic [DATA_WIDTH-1:0] w_data_nxt [NUM-1:0];

  logic w_in_hs;
  logic w_out_hs;
  logic w_last;
  logic w_flush_go;

  // A slot frees up when the held beat is empty or is being drained this cycle.
  // data_in_ready must not depend on data_in_valid.
  assign data_out_valid = (r_state == S_FULL);
  assign data_in_ready  = !data_out_valid || data_out_ready;
  assign w_in_hs        = data_in_valid && data_in_ready;
  assign w_out_hs       = data_out_valid && data_out_ready;
  assign w_last         = (r_cnt == CNT_W'(K - 1));
  assign data_out       = r_data;

`ifdef UNROLLER_FLUSH_EN
  // The filled count includes any input beat accepted in the same cycle.
  logic [CNT_W:0] w_fill;
  assign w_fill     = {1'b0, r_cnt} + (CNT_W + 1)'(w_in_hs);
  assign w_flush_go = flush && data_in_ready && (w_fill != '0);
`else
  assign w_flush_go = 1'b0;
`endif

  // Next lane contents: the accepted beat goes into lane group r_cnt. With
  // flush enabled, the lane groups beyond the filled count are cleared.
  always_comb begin
    // NOTE: the default assignment covers every path, so no latch is inferred.
    w_data_nxt = r_data;
    for (int i = 0; i < NUM; i++) begin
      if (w_in_hs && (i / ROLL_NUM) == int'(r_cnt)) begin
        w_data_nxt[i] = data_in[i % ROLL_NUM];
      end
`ifdef UNROLLER_FLUSH_EN
      else if (w_flush_go && (i / ROLL_NUM) >= int'(w_fill)) begin
        w_data_nxt[i] = '0;
      end
`endif
    end
  end

  // Beat counter, FILL/FULL state and the output lane registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the output lanes must read as zero out of reset, so this array is
      // reset explicitly rather than left as an unreset storage array.
      r_state <= S_FILL;
      r_cnt   <= '0;
      for (int i = 0; i < NUM; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      // NOTE: all state here uses non-blocking assignments, so every branch
      // reads the values from before this clock edge.
      r_data <= w_data_nxt;

      if (w_flush_go) begin
        r_cnt <= '0;
      end else if (w_in_hs) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end

      if ((w_in_hs && w_last) || w_flush_go) begin
        r_state <= S_FULL;
      end else if (w_out_hs) begin
        r_state <= S_FILL;
      end
    end
  end

endmodule
